mvu_quantser: RTL
=================

Name: mvu_quantser

Overview:
- Parametrised quantizer/serializer that sits between the MVU scaler output and the data-bank write path.
- Accepts one vector of N signed scaler results, each BIN bits wide.
- Extracts a programmable bit window per lane (MSB index and output bit depth), with optional saturation.
- Emits the result bit-serially, MSB plane first: one N-bit plane per cycle, matching the bit-serial activation word format.

Parameters:
- N, 64, number of lanes (= data bank word width)
- BIN, 48, input bitwidth per lane (scaler output width)
- BMSB, 6, bitwidth of msbidx input; must be >= clog2(BIN)
- BPREC, 6, bitwidth of bwout input
- BPMAX, 32, maximum output precision in bits; must be <= BIN

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input vector valid
- in_ready  output  1  block can accept a vector
- in_data  input  N*BIN  lane i in bits [i*BIN +: BIN], two's complement
- msbidx  input  BMSB  bit position of window MSB
- bwout  input  BPREC  output precision in bits
- sat_en  input  1  1 = saturate on overflow, 0 = wrap (plain extraction)
- out_valid  output  1  bit plane valid
- out_ready  input  1  downstream accepts plane
- out_data  output  N  current bit plane; bit i belongs to lane i
- out_last  output  1  high with the final (LSB) plane of a vector
- busy  output  1  high while in SHIFT

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0. State goes to IDLE.
- Reset mid-operation discards the held vector and remaining planes.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, move to SHIFT.
  - SHIFT: out_valid=1.
- Input handshake:
  - msbidx, bwout and sat_en are sampled on the same clock as the in_valid&in_ready handshake.
  - Changes to these inputs during SHIFT have no effect on the vector in flight.
- Effective configuration:
  - bw = bwout, except bwout=0 gives bw=1 and bwout>BPMAX gives bw=BPMAX.
  - m = msbidx, except msbidx>BIN-1 gives m=BIN-1.
- Window extraction per lane x:
  - The window is bits x[m] down to x[m-bw+1].
  - Window positions below bit 0 read as 0 (zero padding).
- Overflow per lane: bits x[BIN-1:m] are not all equal.
- sat_en=1 with overflow:
  - x[BIN-1]=0 gives window 0 followed by bw-1 ones.
  - x[BIN-1]=1 gives window 1 followed by bw-1 zeros.
- sat_en=0: the window is used unmodified, whether or not it overflowed.
- Quantized windows are registered on the acceptance edge into a shift register of N x BPMAX bits.
- First plane (window MSB) appears on out_data with out_valid=1 in the cycle after acceptance (latency 1).
- Output handshake:
  - The plane advances only on out_valid&out_ready.
  - While out_ready=0, out_data, out_last and out_valid are held stable.
- The plane counter counts bw planes. out_last=1 on plane index bw-1.
- Handshake on the last plane returns to IDLE. out_valid drops the next cycle unless a new vector was accepted.
- Back-to-back transfers:
  - in_ready = IDLE | (SHIFT & out_last & out_ready), combinational from state and out_ready.
  - A vector accepted on the last-plane handshake loads directly. Its first plane is valid the next cycle with no bubble, and the state stays SHIFT.
- busy = (state==SHIFT).
- in_ready=0 while in SHIFT and not on the last-plane handshake; in_valid is ignored then.
- bw=1 gives a single plane with out_last=1.

Test Plan:
- Reset: assert rst asynchronously mid-SHIFT -> out_valid=0, out_data=0, out_last=0, busy=0 and in_ready=1 immediately; no further planes after release.
- Extraction: msbidx=7, bwout=4, sat_en=0, lane0=0x0000000000A5, lane1=0x000000000005, other lanes 0 -> planes bit0 = 1,0,1,0 and bit1 = 0,0,0,0. out_last on 4th plane only. First plane one cycle after accept.
- Saturation, same config with sat_en=1: lane0=0x000000000100 -> 0,1,1,1; lane1=0xFFFFFFFFFF00 -> 1,0,0,0. With sat_en=0, both lanes -> 0,0,0,0.
- Backpressure: out_ready=0 for 3 cycles on plane 2 -> out_data, out_valid and out_last unchanged across the stall; total of exactly 4 handshakes.
- Back-to-back: second vector held valid during the first vector's last plane with out_ready=1 -> accepted that cycle (in_ready=1), its first plane on the next cycle, out_valid continuous.
- Padding and clamping:
  - msbidx=2, bwout=6, lane0=0x5 -> 1,0,1,0,0,0.
  - bwout=0 -> single plane with out_last=1.
  - bwout=63 -> 32 planes.
  - msbidx=60 is treated as 47.

Source files
------------

// File: rtl/mvu_quantser.sv
// Quantizer/serializer between the MVU scaler and the data-bank write path.
// Extracts a per-lane bit window (optionally saturated) and emits it one bit plane per cycle, MSB first.
module mvu_quantser #(
    parameter int N     = 64,
    parameter int BIN   = 48,
    parameter int BMSB  = 6,
    parameter int BPREC = 6,
    parameter int BPMAX = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*BIN-1:0]   in_data,
    input  logic [BMSB-1:0]    msbidx,
    input  logic [BPREC-1:0]   bwout,
    input  logic               sat_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_data,
    output logic               out_last,
    output logic               busy
);
    localparam int CW = (BPMAX > 1) ? $clog2(BPMAX) : 1;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t               state_q;
    logic [N*BPMAX-1:0]   shreg_q;
    logic [N*BPMAX-1:0]   load_d;
    logic [N*BPMAX-1:0]   shift_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        bwm1_q;
    logic [BPREC-1:0]     bw_eff;
    logic [BMSB-1:0]      m_eff;
    logic                 accept;
    logic                 fire;

    // Window is left-aligned in BPMAX bits: bit BPMAX-1 is the first plane.
    function automatic logic [BPMAX-1:0] quant(input logic [BIN-1:0] x,
                                               input logic [BMSB-1:0] m,
                                               input logic [BPREC-1:0] bw,
                                               input logic sat);
        logic [BIN+BPMAX-1:0] ext;
        logic [BIN+BPMAX-1:0] sh;
        logic [BIN-1:0]       hi;
        logic [BPMAX-1:0]     mask;
        logic [BPMAX-1:0]     msb1;
        logic [BPMAX-1:0]     win;
        logic                 ovf;
        ext  = {x, {BPMAX{1'b0}}};
        sh   = ext >> ({1'b0, m} + 1'b1);
        mask = ~({BPMAX{1'b1}} >> bw);
        msb1 = {1'b1, {(BPMAX-1){1'b0}}};
        hi   = $signed(x) >>> m;
        ovf  = (hi != '0) && (hi != '1);
        if (sat && ovf) begin
            win = x[BIN-1] ? msb1 : (mask & ~msb1);
        end else begin
            win = sh[BPMAX-1:0] & mask;
        end
        return win;
    endfunction

    always_comb begin
        bw_eff = bwout;
        if (bwout == '0) begin
            bw_eff = BPREC'(1);
        end else if (bwout > BPREC'(BPMAX)) begin
            bw_eff = BPREC'(BPMAX);
        end
        m_eff = (msbidx > BMSB'(BIN-1)) ? BMSB'(BIN-1) : msbidx;
    end

    always_comb begin
        load_d  = '0;
        shift_d = '0;
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            load_d[i*BPMAX +: BPMAX]  = quant(in_data[i*BIN +: BIN], m_eff, bw_eff, sat_en);
            shift_d[i*BPMAX +: BPMAX] = {shreg_q[i*BPMAX +: BPMAX-1], 1'b0};
            out_data[i] = busy & shreg_q[i*BPMAX + BPMAX-1];
        end
    end

    assign busy      = (state_q == SHIFT);
    assign out_valid = busy;
    assign out_last  = busy && (cnt_q == bwm1_q);
    assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            bwm1_q  <= '0;
        end else if (accept) begin
            state_q <= SHIFT;
            shreg_q <= load_d;
            cnt_q   <= '0;
            bwm1_q  <= CW'(bw_eff - 1'b1);
        end else if (fire) begin
            shreg_q <= shift_d;
            cnt_q   <= cnt_q + 1'b1;
            if (out_last) begin
                state_q <= IDLE;
            end
        end
    end
endmodule
